// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end for a single bit-serial adder.
// The winner's operands are captured and added LSB-first over WIDTH cycles.

module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_add_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             last_q, last_d;
  logic             winner_q, winner_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, done_q, done_d;
  logic             owner_q, owner_d, cout_q, cout_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             fa_s, fa_co;
  logic             pick1;

  fulladder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // With both requesting, the one that was not served last wins.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    s_sh_d   = s_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    last_d   = last_q;
    winner_d = winner_q;
    owner_d  = owner_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          winner_d = pick1;
          last_d   = pick1;
          a_sh_d   = pick1 ? a1 : a0;
          b_sh_d   = pick1 ? b1 : b0;
          carry_d  = pick1 ? cin1 : cin0;
          cnt_d    = '0;
          gnt0_d   = ~pick1;
          gnt1_d   = pick1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The last sum bit is folded in here so sum is complete on DONE entry.
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          owner_d = winner_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      s_sh_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done_q   <= 1'b0;
      owner_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      s_sh_q   <= s_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done_q   <= done_d;
      owner_q  <= owner_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign owner = owner_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: table of single adds plus hand-written
// arbitration, mid-run request and mid-run reset sequences.

module tb_serial_add_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, owner, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns at the negedge of the grant cycle; c = -1 on timeout.
  task automatic wait_gnt(output int c, output logic which);
    bit found = 0;
    c = -1;
    which = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        found = 1;
        c = cyc;
        which = gnt1;
      end
    end
    if (!found) check("gnt_timeout", 0, 1);
  endtask

  // Returns at the negedge of the done cycle; counts grants seen on the way.
  task automatic wait_done(output int c, output int gnts);
    bit found = 0;
    c = -1;
    gnts = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) gnts++;
      if (done) begin
        found = 1;
        c = cyc;
      end
    end
    if (!found) check("done_timeout", 0, 1);
  endtask

  task automatic drive(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (sel) begin
      req1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; cin0 = cin;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int   gc, dc, gc1, prev_gc, gseen, dcount;
  logic which;

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_owner", owner, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    // Single-requester table; operands are scrambled after grant to prove latching.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_gnt(gc, which);
      check($sformatf("v%0d_gnt_id", i), which, vecs[i].sel);
      check($sformatf("v%0d_busy_at_gnt", i), busy, 1);
      req0 = 1'b0; req1 = 1'b0;
      a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; cin0 = ~cin0; cin1 = ~cin1;
      wait_done(dc, gseen);
      check($sformatf("v%0d_latency", i), dc - gc, W);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("v%0d_owner", i), owner, vecs[i].sel);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
    end

    // Both held from reset: grants alternate 0,1,0,1 with an 18-cycle period.
    do_reset();
    drive(1'b0, 16'h0102, 16'h0304, 1'b0);
    drive(1'b1, 16'hF000, 16'h2000, 1'b1);
    prev_gc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(gc, which);
      check($sformatf("rr%0d_gnt_id", k), which, k % 2);
      if (k > 0) check($sformatf("rr%0d_period", k), gc - prev_gc, W + 2);
      prev_gc = gc;
      wait_done(dc, gseen);
      check($sformatf("rr%0d_owner", k), owner, k % 2);
      check($sformatf("rr%0d_sum", k), sum, (k % 2) ? 16'h1001 : 16'h0406);
      check($sformatf("rr%0d_cout", k), cout, (k % 2) ? 1 : 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // req1 arrives mid-run of requester 0: it waits, and results hold until its done.
    drive(1'b0, 16'h1111, 16'h2222, 1'b1);
    wait_gnt(gc, which);
    check("mid_gnt_id", which, 0);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    drive(1'b1, 16'h8001, 16'h8001, 1'b0);
    wait_done(dc, gseen);
    check("mid_no_early_gnt", gseen, 0);
    check("mid_sum0", sum, 16'h3334);
    check("mid_cout0", cout, 0);
    check("mid_owner0", owner, 0);
    wait_gnt(gc1, which);
    check("mid_gnt1_id", which, 1);
    check("mid_gnt1_delay", gc1 - dc, 2);
    req1 = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_hold_sum", sum, 16'h3334);
    check("mid_hold_owner", owner, 0);
    wait_done(dc, gseen);
    check("mid_sum1", sum, 16'h0002);
    check("mid_cout1", cout, 1);
    check("mid_owner1", owner, 1);
    repeat (2) @(negedge clk);

    // Reset at RUN cycle 8: outputs clear at once, no done, pointer back to requester 0.
    drive(1'b0, 16'h00FF, 16'h0001, 1'b0);
    wait_gnt(gc, which);
    req0 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("arst_no_done", dcount, 0);
    drive(1'b0, 16'hABCD, 16'h1111, 1'b0);
    drive(1'b1, 16'h0F0F, 16'h0101, 1'b0);
    wait_gnt(gc, which);
    check("arst_prio_gnt", which, 0);
    req0 = 1'b0;
    wait_done(dc, gseen);
    check("arst_sum0", sum, 16'hBCDE);
    check("arst_owner0", owner, 0);
    wait_gnt(gc1, which);
    check("arst_gnt1_id", which, 1);
    req1 = 1'b0;
    wait_done(dc, gseen);
    check("arst_sum1", sum, 16'h1010);
    check("arst_owner1", owner, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
